// File: rtl/alu_issue_decoder_pkg.sv
// Shared types and RV32I encoding constants for the ALU issue decoder.
package alu_issue_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned OPCODE_LENGTH = 4;
  localparam int unsigned REG_ADDR_W    = 5;

  typedef enum logic [OPCODE_LENGTH-1:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluSlti = 4'b1000,
    AluSlt  = 4'b1001,
    AluAddi = 4'b1010,
    AluBeq  = 4'b1011,
    AluBne  = 4'b1100,
    AluBlt  = 4'b1101,
    AluBge  = 4'b1110
  } alu_op_e;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Shr    = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [2:0] F3Blt    = 3'b100;
  localparam logic [2:0] F3Bge    = 3'b101;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    alu_op_e                 op;
    logic [REG_ADDR_W-1:0]   rs1;
    logic [REG_ADDR_W-1:0]   rs2;
    logic [REG_ADDR_W-1:0]   rd;
    logic [DATA_WIDTH-1:0]   imm;
    logic                    alu_src;
    logic                    use_rs1;
    logic                    reg_write;
    logic                    is_branch;
    logic                    is_load;
    logic                    is_store;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   pc;
  } decoded_t;

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the ALU issue decoder.
interface alu_issue_decoder_if;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [alu_issue_pkg::DATA_WIDTH-1:0]       in_instr;
  logic [alu_issue_pkg::DATA_WIDTH-1:0]       in_pc;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [alu_issue_pkg::OPCODE_LENGTH-1:0]    out_op;
  logic [alu_issue_pkg::REG_ADDR_W-1:0]       out_rs1;
  logic [alu_issue_pkg::REG_ADDR_W-1:0]       out_rs2;
  logic [alu_issue_pkg::REG_ADDR_W-1:0]       out_rd;
  logic [alu_issue_pkg::DATA_WIDTH-1:0]       out_imm;
  logic                                       out_alu_src;
  logic                                       out_use_rs1;
  logic                                       out_reg_write;
  logic                                       out_is_branch;
  logic                                       out_is_load;
  logic                                       out_is_store;
  logic                                       out_illegal;
  logic [alu_issue_pkg::DATA_WIDTH-1:0]       out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_imm, out_alu_src,
           out_use_rs1, out_reg_write, out_is_branch, out_is_load, out_is_store,
           out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rs1, out_rs2, out_rd, out_imm, out_alu_src,
           out_use_rs1, out_reg_write, out_is_branch, out_is_load, out_is_store,
           out_illegal, out_pc
  );
endinterface

// File: rtl/alu_issue_decoder_op_decode.sv
// Combinational RV32I instruction to ALU issue bundle decoder.
module rv32i_alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output decoded_t              o_dec
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_shamt;
  logic                  w_legal, w_wr, w_alu_src, w_use_rs1, w_br, w_ld, w_st;
  alu_op_e               w_op;
  logic [DATA_WIDTH-1:0] w_imm;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_shamt  = {27'b0, i_instr[24:20]};

  always_comb begin
    w_legal   = 1'b0;
    w_op      = AluAdd;
    w_imm     = '0;
    w_alu_src = 1'b0;
    w_use_rs1 = 1'b1;
    w_wr      = 1'b0;
    w_br      = 1'b0;
    w_ld      = 1'b0;
    w_st      = 1'b0;
    case (w_opcode)
      OpcOp: begin
        w_wr = 1'b1;
        case (w_funct3)
          F3AddSub: begin
            w_legal = (w_funct7 == F7Base) || (w_funct7 == F7Alt);
            w_op    = (w_funct7 == F7Alt) ? AluSub : AluAdd;
          end
          F3Shr: begin
            w_legal = (w_funct7 == F7Base) || (w_funct7 == F7Alt);
            w_op    = (w_funct7 == F7Alt) ? AluSra : AluSrl;
          end
          F3Sll:   begin w_legal = (w_funct7 == F7Base); w_op = AluSll; end
          F3Slt:   begin w_legal = (w_funct7 == F7Base); w_op = AluSlt; end
          F3Xor:   begin w_legal = (w_funct7 == F7Base); w_op = AluXor; end
          F3Or:    begin w_legal = (w_funct7 == F7Base); w_op = AluOr;  end
          F3And:   begin w_legal = (w_funct7 == F7Base); w_op = AluAnd; end
          default: w_legal = 1'b0;
        endcase
      end
      OpcOpImm: begin
        w_wr      = 1'b1;
        w_alu_src = 1'b1;
        w_imm     = w_imm_i;
        case (w_funct3)
          F3AddSub: begin w_legal = 1'b1; w_op = AluAddi; end
          F3Slt:    begin w_legal = 1'b1; w_op = AluSlti; end
          F3Xor:    begin w_legal = 1'b1; w_op = AluXor;  end
          F3Or:     begin w_legal = 1'b1; w_op = AluOr;   end
          F3And:    begin w_legal = 1'b1; w_op = AluAnd;  end
          F3Sll: begin
            w_legal = (w_funct7 == F7Base);
            w_op    = AluSll;
            w_imm   = w_shamt;
          end
          F3Shr: begin
            w_legal = (w_funct7 == F7Base) || (w_funct7 == F7Alt);
            w_op    = (w_funct7 == F7Alt) ? AluSra : AluSrl;
            w_imm   = w_shamt;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OpcLoad: begin
        w_legal   = w_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        w_alu_src = 1'b1;
        w_imm     = w_imm_i;
        w_ld      = 1'b1;
        w_wr      = 1'b1;
      end
      OpcStore: begin
        w_legal   = w_funct3 inside {3'd0, 3'd1, 3'd2};
        w_alu_src = 1'b1;
        w_imm     = w_imm_s;
        w_st      = 1'b1;
      end
      OpcBranch: begin
        w_imm = w_imm_b;
        w_br  = 1'b1;
        case (w_funct3)
          F3Beq:   begin w_legal = 1'b1; w_op = AluBeq; end
          F3Bne:   begin w_legal = 1'b1; w_op = AluBne; end
          F3Blt:   begin w_legal = 1'b1; w_op = AluBlt; end
          F3Bge:   begin w_legal = 1'b1; w_op = AluBge; end
          default: w_legal = 1'b0;
        endcase
      end
      OpcLui: begin
        w_legal   = 1'b1;
        w_use_rs1 = 1'b0;
        w_alu_src = 1'b1;
        w_imm     = w_imm_u;
        w_wr      = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal encodings carry only register fields and PC; everything else is zeroed.
  always_comb begin
    o_dec     = '0;
    o_dec.rs1 = i_instr[19:15];
    o_dec.rs2 = i_instr[24:20];
    o_dec.rd  = w_rd;
    o_dec.pc  = i_pc;
    if (w_legal) begin
      o_dec.op        = w_op;
      o_dec.imm       = w_imm;
      o_dec.alu_src   = w_alu_src;
      o_dec.use_rs1   = w_use_rs1;
      o_dec.reg_write = w_wr && (w_rd != '0);
      o_dec.is_branch = w_br;
      o_dec.is_load   = w_ld;
      o_dec.is_store  = w_st;
    end else begin
      o_dec.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decode stage with a registered output slot plus one skid slot between fetch and execute.
module alu_issue_decoder
  import alu_issue_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  alu_issue_decoder_if.slave bus
);

  decoded_t w_dec;
  decoded_t r_out;
  decoded_t r_skid;
  logic     r_out_valid;
  logic     r_skid_valid;
  logic     w_accept;
  logic     w_out_free;

  rv32i_alu_op_decode u_decode (
    .i_instr (bus.in_instr),
    .i_pc    (bus.in_pc),
    .o_dec   (w_dec)
  );

  // Ready depends only on the skid flop, so no combinational path from out_ready.
  assign w_accept   = bus.in_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready      = !r_skid_valid;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_op        = r_out.op;
  assign bus.out_rs1       = r_out.rs1;
  assign bus.out_rs2       = r_out.rs2;
  assign bus.out_rd        = r_out.rd;
  assign bus.out_imm       = r_out.imm;
  assign bus.out_alu_src   = r_out.alu_src;
  assign bus.out_use_rs1   = r_out.use_rs1;
  assign bus.out_reg_write = r_out.reg_write;
  assign bus.out_is_branch = r_out.is_branch;
  assign bus.out_is_load   = r_out.is_load;
  assign bus.out_is_store  = r_out.is_store;
  assign bus.out_illegal   = r_out.illegal;
  assign bus.out_pc        = r_out.pc;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Randomised and directed bench for alu_issue_decoder against a queue-based reference model.
module tb_alu_issue_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef logic [89:0] bundle_t;
  bundle_t model_q[$];

  always #5 clk = ~clk;

  alu_issue_decoder_if bus ();

  alu_issue_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bundle_t dut_bundle();
    return {bus.out_op, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm, bus.out_alu_src,
            bus.out_use_rs1, bus.out_reg_write, bus.out_is_branch, bus.out_is_load,
            bus.out_is_store, bus.out_illegal, bus.out_pc};
  endfunction

  // Instruction-set level reference: mnemonic tables indexed by funct3.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] imm;
    logic        src, use1, wr, br, ld, st, ok;
    logic [3:0]  rops[8];
    logic [3:0]  iops[8];
    logic [3:0]  bops[8];
    int          imm_i, imm_s, imm_b;
    rops  = '{4'd0, 4'd5, 4'd9, 4'd0, 4'd4, 4'd6, 4'd3, 4'd2};
    iops  = '{4'd10, 4'd5, 4'd8, 4'd0, 4'd4, 4'd6, 4'd3, 4'd2};
    bops  = '{4'd11, 4'd12, 4'd0, 4'd0, 4'd13, 4'd14, 4'd0, 4'd0};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    rd    = ins[11:7];
    imm_i = $signed(ins[31:20]);
    imm_s = $signed({ins[31:25], ins[11:7]});
    imm_b = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    op = 4'd0; imm = 32'd0; src = 1'b0; use1 = 1'b1; wr = 1'b0;
    br = 1'b0; ld = 1'b0; st = 1'b0; ok = 1'b0;
    case (opc)
      7'h33: begin
        ok = (f3 != 3'd3) && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        op = rops[f3];
        if (f7 == 7'h20) op = (f3 == 3'd0) ? 4'd1 : 4'd7;
        wr = 1'b1;
      end
      7'h13: begin
        ok = (f3 != 3'd3) && (f3 != 3'd1 || f7 == 7'h00)
             && (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20);
        op = iops[f3];
        if (f3 == 3'd5 && f7 == 7'h20) op = 4'd7;
        imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm_i;
        src = 1'b1; wr = 1'b1;
      end
      7'h03: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        imm = imm_i; src = 1'b1; ld = 1'b1; wr = 1'b1;
      end
      7'h23: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2};
        imm = imm_s; src = 1'b1; st = 1'b1;
      end
      7'h63: begin
        ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
        op = bops[f3]; imm = imm_b; br = 1'b1;
      end
      7'h37: begin
        ok = 1'b1; imm = {ins[31:12], 12'd0}; src = 1'b1; use1 = 1'b0; wr = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {4'd0, ins[19:15], ins[24:20], rd, 32'd0, 6'd0, 1'b1, pc};
    return {op, ins[19:15], ins[24:20], rd, imm, src, use1, wr && (rd != 5'd0), br, ld, st,
            1'b0, pc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 7))
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h37;
      6: ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 0) ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return ins;
  endfunction

  // Called at a falling edge: check outputs, drive one cycle, advance the model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic exp_rdy;
    exp_rdy = (model_q.size() < 2);
    check_eq("in_ready", bus.in_ready, exp_rdy);
    check_eq("out_valid", bus.out_valid, model_q.size() != 0);
    if (model_q.size() != 0) check_eq("bundle", dut_bundle(), model_q[0]);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
      if (v && exp_rdy) model_q.push_back(ref_decode(ins, pc));
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check_eq({tag, "_payload"}, dut_bundle(), '0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decodes with an always-ready consumer.
    cycle(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    check_eq("add_op", bus.out_op, 4'b0000);
    check_eq("add_rs1", bus.out_rs1, 5'd1);
    check_eq("add_rs2", bus.out_rs2, 5'd2);
    check_eq("add_rd", bus.out_rd, 5'd3);
    check_eq("add_alu_src", bus.out_alu_src, 1'b0);
    check_eq("add_reg_write", bus.out_reg_write, 1'b1);
    cycle(1'b1, 32'hFFF00293, 32'h104, 1'b1, 1'b0);
    check_eq("addi_op", bus.out_op, 4'b1010);
    check_eq("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    check_eq("addi_alu_src", bus.out_alu_src, 1'b1);
    cycle(1'b1, 32'h00000013, 32'h108, 1'b1, 1'b0);
    check_eq("nop_reg_write", bus.out_reg_write, 1'b0);
    cycle(1'b1, 32'h4030D093, 32'h10C, 1'b1, 1'b0);
    check_eq("srai_op", bus.out_op, 4'b0111);
    check_eq("srai_imm", bus.out_imm, 32'd3);
    cycle(1'b1, 32'h12345137, 32'h110, 1'b1, 1'b0);
    check_eq("lui_op", bus.out_op, 4'b0000);
    check_eq("lui_use_rs1", bus.out_use_rs1, 1'b0);
    check_eq("lui_imm", bus.out_imm, 32'h12345000);
    cycle(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    check_eq("bad_opc_illegal", bus.out_illegal, 1'b1);
    check_eq("bad_opc_reg_write", bus.out_reg_write, 1'b0);
    cycle(1'b1, 32'h0020E063, 32'h118, 1'b1, 1'b0);
    check_eq("bltu_illegal", bus.out_illegal, 1'b1);
    check_eq("bltu_op", bus.out_op, 4'b0000);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Stall: A, B fill both slots, C waits; release drains strictly in order.
    cycle(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 32'h40208233, 32'h204, 1'b0, 1'b0);
    check_eq("stall_in_ready", bus.in_ready, 1'b0);
    cycle(1'b1, 32'h0020C2B3, 32'h208, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020C2B3, 32'h208, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020C2B3, 32'h208, 1'b1, 1'b0);
    cycle(1'b1, 32'h0020C2B3, 32'h208, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a full buffer, then flush on a cycle that accepts a beat.
    cycle(1'b1, 32'h00112023, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h00812183, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, 32'h00208463, 32'h308, 1'b0, 1'b1);
    check_eq("flush_out_valid", bus.out_valid, 1'b0);
    check_eq("flush_in_ready", bus.in_ready, 1'b1);
    cycle(1'b1, 32'h00208463, 32'h30C, 1'b1, 1'b1);
    check_eq("flush_drop_valid", bus.out_valid, 1'b0);
    cycle(1'b1, 32'h00208463, 32'h310, 1'b1, 1'b0);
    check_eq("post_flush_op", bus.out_op, 4'b1011);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, 32'h002081B3, 32'h400, 1'b0, 1'b0);
    cycle(1'b1, 32'h002081B3, 32'h404, 1'b0, 1'b0);
    cycle(1'b1, 32'h002081B3, 32'h408, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    for (int n = 0; n < 4; n++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
